fc_neuron_mac: RTL and testbench

- Sequential, parametrised multiply-accumulate neuron for the fully-connected layer.
- Computes one output as bias + sum(weight_i * value_i) over NUM_INPUTS signed fixed-point operands.
- Operands stream in LANES pairs per beat under a valid/ready handshake; the output register waits for downstream acceptance.
- Adds saturation, an overflow flag and an optional ReLU to the previous single-shot combinational ALU.

---
 rtl/fc_neuron_mac.sv | 132 +++++++++++++
 tb/tb_fc_neuron_mac.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_mac.sv
// Streaming multiply-accumulate neuron: bias + sum(w*v) over NUM_INPUTS operands,
// LANES pairs per beat, with saturation, overflow flag and optional ReLU.
module fc_neuron_mac #(
  parameter int SIZE       = 16,
  parameter int PRECISION  = 11,
  parameter int LANES      = 4,
  parameter int NUM_INPUTS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [SIZE-1:0]             i_bias,
  input  logic                        i_relu,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [LANES-1:0][SIZE-1:0]  i_values,
  input  logic [LANES-1:0][SIZE-1:0]  i_weights,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [SIZE-1:0]             o_value,
  output logic                        o_overflow,
  output logic                        o_busy
);

  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int ACC_W = 2*SIZE + $clog2(NUM_INPUTS+1) + 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EXT_W = ACC_W - SIZE - PRECISION;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_relu;

  logic signed [2*SIZE-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_beat_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_shift;
  logic [SIZE-1:0]          w_sat;
  logic                     w_ovf;
  logic [SIZE-1:0]          w_res;
  logic                     w_accept;
  logic                     w_last;

  assign w_accept = i_valid && o_ready;
  assign w_last   = (r_cnt == CNT_W'(BEATS-1));

  always_comb begin
    w_prod     = '0;
    w_beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_prod     = $signed({{SIZE{i_weights[k][SIZE-1]}}, i_weights[k]}) *
                   $signed({{SIZE{i_values[k][SIZE-1]}},  i_values[k]});
      w_beat_sum = w_beat_sum + $signed({{(ACC_W-2*SIZE){w_prod[2*SIZE-1]}}, w_prod});
    end
    w_acc_next = r_acc + w_beat_sum;
  end

  // Result is taken from the post-beat sum so it can be registered on the last beat.
  always_comb begin
    w_shift = w_acc_next >>> PRECISION;
    w_ovf   = 1'b0;
    if (w_shift > SAT_MAX) begin
      w_sat = {1'b0, {(SIZE-1){1'b1}}};
      w_ovf = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_sat = {1'b1, {(SIZE-1){1'b0}}};
      w_ovf = 1'b1;
    end else begin
      w_sat = w_shift[SIZE-1:0];
    end
    w_res = (r_relu && w_sat[SIZE-1]) ? '0 : w_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_relu     <= 1'b0;
      o_ready    <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_value    <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc   <= $signed({{EXT_W{i_bias[SIZE-1]}}, i_bias, {PRECISION{1'b0}}});
            r_relu  <= i_relu;
            r_cnt   <= '0;
            o_ready <= 1'b1;
            o_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              o_ready    <= 1'b0;
              o_valid    <= 1'b1;
              o_value    <= w_res;
              o_overflow <= w_ovf;
              r_state    <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed-vector bench for fc_neuron_mac with hand-computed Q5.11 results.
module tb_fc_neuron_mac;

  localparam int SIZE  = 16;
  localparam int LANES = 4;
  localparam int NIN   = 16;
  localparam int BEATS = NIN / LANES;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_start;
  logic [SIZE-1:0]            i_bias;
  logic                       i_relu;
  logic                       i_valid;
  logic                       o_ready;
  logic [LANES-1:0][SIZE-1:0] i_values;
  logic [LANES-1:0][SIZE-1:0] i_weights;
  logic                       o_valid;
  logic                       i_ready;
  logic [SIZE-1:0]            o_value;
  logic                       o_overflow;
  logic                       o_busy;

  fc_neuron_mac #(
    .SIZE(SIZE),
    .PRECISION(11),
    .LANES(LANES),
    .NUM_INPUTS(NIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_bias(i_bias),
    .i_relu(i_relu),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_values(i_values),
    .i_weights(i_weights),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_value(o_value),
    .o_overflow(o_overflow),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bias;
    logic        relu;
    logic [15:0] w;
    logic [15:0] v;
    logic        lane0;
    logic [15:0] exp_v;
    logic        exp_o;
  } vec_t;

  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input vec_t t, input int b);
    for (int k = 0; k < LANES; k++) begin
      if (t.lane0 && !(b == 0 && k == 0)) begin
        i_weights[k] = '0;
        i_values[k]  = '0;
      end else begin
        i_weights[k] = t.w;
        i_values[k]  = t.v;
      end
    end
  endtask

  task automatic run_op(input vec_t t, input bit bubbles, input int hold, input bit noise,
                        input string tag);
    int cyc;
    cyc = 0;
    if (noise) begin
      set_beat(t, 0);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk({tag, "_idle_ready"}, o_ready, 0);
      chk({tag, "_idle_busy"}, o_busy, 0);
    end
    i_start = 1'b1;
    i_bias  = t.bias;
    i_relu  = t.relu;
    tick(); cyc++;
    i_start = 1'b0;
    i_bias  = 16'h5A5A;
    i_relu  = ~t.relu;
    chk({tag, "_accum_ready"}, o_ready, 1);
    chk({tag, "_accum_busy"}, o_busy, 1);
    for (int b = 0; b < BEATS; b++) begin
      set_beat(t, b);
      i_valid = 1'b1;
      tick(); cyc++;
      i_valid = 1'b0;
      if (bubbles && b < BEATS-1) begin
        i_weights = {LANES{16'h7FFF}};
        i_values  = {LANES{16'h7FFF}};
        i_start   = noise;
        tick(); cyc++;
        i_start   = 1'b0;
        chk({tag, "_bubble_ready"}, o_ready, 1);
        chk({tag, "_bubble_valid"}, o_valid, 0);
      end
    end
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_ready_low"}, o_ready, 0);
    chk({tag, "_value"}, o_value, t.exp_v);
    chk({tag, "_ovf"}, o_overflow, t.exp_o);
    for (int h = 0; h < hold; h++) begin
      i_start = noise;
      tick(); cyc++;
      i_start = 1'b0;
      chk({tag, "_hold_valid"}, o_valid, 1);
      chk({tag, "_hold_value"}, o_value, t.exp_v);
    end
    i_ready = 1'b1;
    tick(); cyc++;
    i_ready = 1'b0;
    chk({tag, "_done_valid"}, o_valid, 0);
    chk({tag, "_done_busy"}, o_busy, 0);
    chk({tag, "_kept_value"}, o_value, t.exp_v);
    if (!bubbles && hold == 0) chk({tag, "_cycles"}, cyc, BEATS + 2);
  endtask

  initial begin
    //                bias     relu  w         v         lane0 exp_v     exp_o
    vecs[0] = '{16'h0400, 1'b0, 16'h0800, 16'h0200, 1'b0, 16'h2400, 1'b0};
    vecs[1] = '{16'h0000, 1'b0, 16'h3800, 16'h3800, 1'b0, 16'h7FFF, 1'b1};
    vecs[2] = '{16'h0000, 1'b0, 16'h3800, 16'hC800, 1'b0, 16'h8000, 1'b1};
    vecs[3] = '{16'h0000, 1'b1, 16'h3800, 16'hC800, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h0000, 1'b0, 16'hFFFF, 16'h0400, 1'b1, 16'hFFFF, 1'b0};
    vecs[5] = '{16'h0000, 1'b0, 16'h0001, 16'h0400, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{16'h0400, 1'b1, 16'h0800, 16'h0200, 1'b0, 16'h2400, 1'b0};
    vecs[7] = '{16'hF800, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hF800, 1'b0};
    vecs[8] = '{16'hF800, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[9] = '{16'h7FFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 1'b0};

    rst       = 1'b1;
    i_start   = 1'b0;
    i_bias    = '0;
    i_relu    = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_values  = '0;
    i_weights = '0;
    #22;
    chk("rst_value", o_value, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int n = 0; n < 10; n++) run_op(vecs[n], 1'b0, 0, 1'b0, $sformatf("vec%0d", n));

    run_op(vecs[0], 1'b1, 5, 1'b0, "flow");
    run_op(vecs[0], 1'b1, 2, 1'b1, "ignore");

    // Asynchronous reset between edges after two accepted beats.
    i_start = 1'b1;
    i_bias  = vecs[1].bias;
    i_relu  = 1'b0;
    tick();
    i_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      set_beat(vecs[1], b);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_value", o_value, 0);
    #1 rst = 1'b0;
    tick();
    run_op(vecs[0], 1'b0, 0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
